clb_slice_regs: RTL and testbench

- Output register stage directly downstream of the F7/F8 mux slice inside a CLB.
- Takes the NUM_LUTS mux outputs and drives the slice outputs. Each bit can be registered (with init value, clock enable and synchronous set/reset-to-init) or passed through combinationally.
- Configuration loads through a serial shift chain on the shared config clock. A small state machine sequences CONFIG -> INIT -> RUN.

---
 rtl/clb_pkg.sv | 30 +++
 rtl/clb_cfg_chain.sv | 28 ++
 rtl/clb_slice_regs.sv | 100 ++++++++++
 tb/tb_clb_slice_regs.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared CLB definitions: config chain bit layout and sequencing states.
package clb_pkg;

  typedef enum logic [1:0] {
    CONFIG = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2
  } clb_state_e;

  function automatic int bypass_off(input int i);
    return 2 * i;
  endfunction

  function automatic int init_off(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int ce_en_off(input int n);
    return 2 * n;
  endfunction

  function automatic int sr_en_off(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int cfg_bits(input int n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/clb_cfg_chain.sv
// Serial config shift register with optional masked parallel capture.
module clb_cfg_chain #(
  parameter int CFG_BITS = 6
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                shift,
  input  logic                capture,
  input  logic [CFG_BITS-1:0] cap_mask,
  input  logic [CFG_BITS-1:0] cap_data,
  input  logic                config_in,
  output logic [CFG_BITS-1:0] chain,
  output logic                config_out
);

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (capture) begin
      chain <= (chain & ~cap_mask) | (cap_data & cap_mask);
    end else if (shift) begin
      chain <= {config_in, chain[CFG_BITS-1:1]};
    end
  end

  assign config_out = chain[0];

endmodule

// File: rtl/clb_slice_regs.sv
// CLB slice output registers with serial config and CONFIG/INIT/RUN sequencing.
// CLB_SLICE_REGS_READBACK_EN adds capture of flop state into the chain.
module clb_slice_regs
  import clb_pkg::*;
#(
  parameter int NUM_LUTS = 2
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                config_in,
  output logic                config_out,
  input  logic                readback,
  input  logic [NUM_LUTS-1:0] d,
  input  logic                ce,
  input  logic                sr,
  output logic [NUM_LUTS-1:0] q,
  output logic                running
);

  localparam int CFG_BITS = cfg_bits(NUM_LUTS);

  logic [CFG_BITS-1:0] chain;
  logic [CFG_BITS-1:0] cap_mask;
  logic [CFG_BITS-1:0] cap_data;
  logic                shift;
  logic                capture;
  logic [NUM_LUTS-1:0] flop;
  logic [NUM_LUTS-1:0] bypass;
  logic [NUM_LUTS-1:0] init;
  logic                ce_en;
  logic                sr_en;
  clb_state_e          state;

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_bit
    assign bypass[i] = chain[bypass_off(i)];
    assign init[i]   = chain[init_off(i)];
    assign cap_mask[bypass_off(i)] = 1'b0;
    assign cap_mask[init_off(i)]   = 1'b1;
    assign cap_data[bypass_off(i)] = 1'b0;
    assign cap_data[init_off(i)]   = flop[i];
  end

  assign cap_mask[CFG_BITS-1:CFG_BITS-2] = 2'b00;
  assign cap_data[CFG_BITS-1:CFG_BITS-2] = 2'b00;

  assign ce_en = chain[ce_en_off(NUM_LUTS)];
  assign sr_en = chain[sr_en_off(NUM_LUTS)];

`ifdef CLB_SLICE_REGS_READBACK_EN
  assign capture = cen & readback;
  assign shift   = cen & ~readback;
`else
  logic unused_readback;
  assign unused_readback = readback;
  assign capture = 1'b0;
  assign shift   = cen;
`endif

  clb_cfg_chain #(
    .CFG_BITS(CFG_BITS)
  ) u_chain (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .shift     (shift),
    .capture   (capture),
    .cap_mask  (cap_mask),
    .cap_data  (cap_data),
    .config_in (config_in),
    .chain     (chain),
    .config_out(config_out)
  );

  // cen wins in every state: flops hold while the chain is busy
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CONFIG;
      flop  <= '0;
    end else if (cen) begin
      state <= CONFIG;
    end else begin
      unique case (state)
        CONFIG: state <= INIT;
        INIT: begin
          flop  <= init;
          state <= RUN;
        end
        RUN: begin
          if (sr_en && sr) flop <= init;
          else if (!ce_en || ce) flop <= d;
        end
        default: state <= CONFIG;
      endcase
    end
  end

  assign q       = (bypass & d) | (~bypass & flop);
  assign running = (state == RUN);

endmodule

// File: tb/tb_clb_slice_regs.sv
// Self-checking bench for clb_slice_regs (NUM_LUTS=2).
// Readback sequence is exercised when CLB_SLICE_REGS_READBACK_EN is defined.
module tb_clb_slice_regs;

  localparam int N  = 2;
  localparam int CB = 2 * N + 2;
`ifdef CLB_SLICE_REGS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         cclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cen = 1'b0;
  logic         config_in = 1'b0;
  logic         readback = 1'b0;
  logic [N-1:0] d = '0;
  logic         ce = 1'b0;
  logic         sr = 1'b0;
  logic         config_out;
  logic [N-1:0] q;
  logic         running;

  int n_chk = 0;
  int n_err = 0;

  clb_slice_regs #(.NUM_LUTS(N)) dut (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .cen       (cen),
    .config_in (config_in),
    .config_out(config_out),
    .readback  (readback),
    .d         (d),
    .ce        (ce),
    .sr        (sr),
    .q         (q),
    .running   (running)
  );

  always #5 cclk = ~cclk;

  // Reference model: chain as a bit queue, entry 0 is the bit at config_out
  bit       m_chain[$];
  bit [N-1:0] m_flop;
  int       m_mode;

  function automatic bit [N-1:0] m_init();
    bit [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_chain[2*i+1];
    return r;
  endfunction

  function automatic bit [N-1:0] m_q(input bit [N-1:0] dv);
    bit [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_chain[2*i] ? dv[i] : m_flop[i];
    return r;
  endfunction

  task automatic model_reset();
    m_chain = {};
    repeat (CB) m_chain.push_back(1'b0);
    m_flop = '0;
    m_mode = 0;
  endtask

  task automatic model_edge();
    if (cen) begin
      if (RB && readback) begin
        for (int i = 0; i < N; i++) m_chain[2*i+1] = m_flop[i];
      end else begin
        void'(m_chain.pop_front());
        m_chain.push_back(config_in);
      end
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_flop = m_init();
      m_mode = 2;
    end else begin
      if (m_chain[2*N+1] && sr) m_flop = m_init();
      else if (!m_chain[2*N] || ce) m_flop = d;
    end
  endtask

  task automatic check_val(input string nm, input logic [7:0] got,
                           input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    check_val({nm, "_q"}, 8'(q), 8'(m_q(d)));
    check_val({nm, "_cfgout"}, 8'(config_out), 8'(m_chain[0]));
    check_val({nm, "_run"}, 8'(running), 8'(m_mode == 2));
  endtask

  task automatic cyc(input logic c, input logic ci, input logic rb,
                     input logic [N-1:0] dv, input logic cev,
                     input logic srv, input string nm);
    cen = c;
    config_in = ci;
    readback = rb;
    d = dv;
    ce = cev;
    sr = srv;
    @(posedge cclk);
    model_edge();
    #1;
    check_model(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_val("reset_q", 8'(q), 8'h00);
    check_val("reset_cfgout", 8'(config_out), 8'h00);
    check_val("reset_run", 8'(running), 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [CB-1:0] v);
    for (int k = 0; k < CB; k++) cyc(1'b1, v[k], 1'b0, d, 1'b0, 1'b0, "load");
  endtask

  typedef struct {
    logic [N-1:0] d;
    logic         ce;
    logic         sr;
    logic [N-1:0] q;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0]   bits;
    logic [CB-1:0] rbk;
    logic [N-1:0]  dv, prev;

    // Config 110110: flop0 starts at 1, bit 1 bypassed
    tbl[0] = '{d: 2'b00, ce: 1'b1, sr: 1'b0, q: 2'b00};
    tbl[1] = '{d: 2'b11, ce: 1'b0, sr: 1'b0, q: 2'b10};
    tbl[2] = '{d: 2'b11, ce: 1'b1, sr: 1'b0, q: 2'b11};
    tbl[3] = '{d: 2'b00, ce: 1'b1, sr: 1'b1, q: 2'b01};
    tbl[4] = '{d: 2'b10, ce: 1'b1, sr: 1'b0, q: 2'b10};
    tbl[5] = '{d: 2'b01, ce: 1'b0, sr: 1'b1, q: 2'b01};

    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "to_init");
    check_val("init_not_running", 8'(running), 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "to_run");
    check_val("run_running", 8'(running), 8'h01);
    check_val("run_q", 8'(q), 8'h00);
    check_val("run_cfgout", 8'(config_out), 8'h00);

    do_reset();
    load(6'b110110);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "cfg_init");
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "cfg_run");
    check_val("init_q0", 8'(q[0]), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, "ce0_hold");
    check_val("ce0_hold_q", 8'(q), 8'h03);
    cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, "ce1_load");
    check_val("ce1_load_q", 8'(q), 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "sr_prio");
    check_val("sr_prio_q", 8'(q), 8'h01);
    d = 2'b10;
    #1;
    check_val("bypass_zero_lat", 8'(q), 8'h03);
    foreach (tbl[i]) begin
      cyc(1'b0, 1'b0, 1'b0, tbl[i].d, tbl[i].ce, tbl[i].sr, "tbl");
      check_val($sformatf("tbl%0d_q", i), 8'(q), 8'(tbl[i].q));
    end

    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "plain_init");
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "plain_run");
    for (int k = 0; k < 20; k++) begin
      dv = 2'($urandom);
      cyc(1'b0, 1'b0, 1'b0, dv, 1'($urandom), 1'($urandom), "plain");
      check_val("lat1_edge", 8'(q), 8'(dv));
      prev = dv;
      d = 2'($urandom);
      #1;
      check_val("lat1_hold", 8'(q), 8'(prev));
    end

    do_reset();
    bits = 12'($urandom);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, bits[k], 1'b0, 2'b00, 1'b0, 1'b0, "daisy");
      if (k + 1 >= CB) check_val("daisy_delay", 8'(config_out), 8'(bits[k-5]));
      else check_val("daisy_fill", 8'(config_out), 8'h00);
    end
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "pre_rst");
    do_reset();
    for (int k = 0; k < CB; k++) begin
      check_val("rst_mid_zero", 8'(config_out), 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "rst_mid");
    end

    if (RB) begin
      do_reset();
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "rb_init");
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "rb_run");
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, "rb_set");
      check_val("rb_set_q", 8'(q), 8'h02);
      cyc(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, "rb_cap");
      for (int k = 0; k < CB; k++) begin
        rbk[k] = config_out;
        cyc(1'b1, config_out, 1'b0, 2'b01, 1'b0, 1'b0, "rb_shift");
      end
      check_val("rb_init0", 8'(rbk[1]), 8'h00);
      check_val("rb_init1", 8'(rbk[3]), 8'h01);
      check_val("rb_stream", 8'(rbk), 8'h08);
      cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, "rb_to_init");
      cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, "rb_restore");
      check_val("rb_restore_q", 8'(q), 8'h02);
    end

    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(3) == 0), 1'($urandom), 1'($urandom_range(3) == 0),
            2'($urandom), 1'($urandom), 1'($urandom_range(3) == 0), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
